// File: rtl/rf_wb_sched_if.sv
// rf_wb_sched_if: issue, write-back, hazard-query and register-bank signals of the write-back scheduler
interface rf_wb_sched_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic              iss_ready;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_wd;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_ready;
    logic [ADDR_W-1:0] qa;
    logic [ADDR_W-1:0] qb;
    logic              qa_busy;
    logic              qb_busy;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wd;
    logic [15:0]       commit_cnt;

    modport master (
        output iss_valid, iss_rd, alu_valid, alu_rd, alu_wd, mem_valid, mem_rd, mem_wd, qa, qb,
        input  iss_ready, alu_ready, mem_ready, qa_busy, qb_busy, rf_we, rf_rd, rf_wd, commit_cnt
    );
    modport slave (
        input  iss_valid, iss_rd, alu_valid, alu_rd, alu_wd, mem_valid, mem_rd, mem_wd, qa, qb,
        output iss_ready, alu_ready, mem_ready, qa_busy, qb_busy, rf_we, rf_rd, rf_wd, commit_cnt
    );
endinterface

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: round-robin ALU/load write-back arbiter with destination scoreboard and hazard queries.
// Optional ZERO_REG_EN makes register 0 hardwired zero (never written, never busy).
module rf_wb_sched #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 16
) (
    input logic clk,
    input logic rst,
    rf_wb_sched_if.slave bus
);
`ifdef ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif
    localparam int IW = $clog2(NREGS);

    logic              ptr;
    logic [NREGS-1:0]  busy, busy_n;
    logic              alu_g, mem_g, g, we_n;
    logic [ADDR_W-1:0] g_rd;
    logic [DATA_W-1:0] g_wd;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wd;
    logic [15:0]       commit_cnt;

    function automatic logic trk(input logic [ADDR_W-1:0] a);
        return 32'(a) < NREGS && !(ZR && a == '0);
    endfunction

    function automatic logic pend(input logic [NREGS-1:0] b, input logic [ADDR_W-1:0] a, input logic hit);
        return trk(a) && b[a[IW-1:0]] && !hit;
    endfunction

    // ptr=0 prefers the ALU, ptr=1 prefers the load unit
    always_comb begin
        alu_g  = bus.alu_valid && (!bus.mem_valid || !ptr);
        mem_g  = bus.mem_valid && !alu_g;
        g      = alu_g || mem_g;
        g_rd   = alu_g ? bus.alu_rd : bus.mem_rd;
        g_wd   = alu_g ? bus.alu_wd : bus.mem_wd;
        we_n   = g && trk(g_rd);
        busy_n = busy;
        if (we_n) busy_n[g_rd[IW-1:0]] = 1'b0;
        if (bus.iss_valid && bus.iss_ready && trk(bus.iss_rd)) busy_n[bus.iss_rd[IW-1:0]] = 1'b1;
    end

    assign bus.alu_ready  = alu_g;
    assign bus.mem_ready  = mem_g;
    assign bus.iss_ready  = !pend(busy, bus.iss_rd, g && g_rd == bus.iss_rd);
    assign bus.qa_busy    = pend(busy, bus.qa, g && g_rd == bus.qa);
    assign bus.qb_busy    = pend(busy, bus.qb, g && g_rd == bus.qb);
    assign bus.rf_we      = rf_we;
    assign bus.rf_rd      = rf_rd;
    assign bus.rf_wd      = rf_wd;
    assign bus.commit_cnt = commit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= 1'b0;
            busy       <= '0;
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_wd      <= '0;
            commit_cnt <= '0;
        end else begin
            if (g) begin
                ptr   <= alu_g;
                rf_rd <= g_rd;
                rf_wd <= g_wd;
            end
            busy       <= busy_n;
            rf_we      <= we_n;
            commit_cnt <= commit_cnt + 16'(we_n);
        end
    end
endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: directed plan checks plus randomized traffic compared each cycle against a behavioural model
module tb_rf_wb_sched;
`ifdef ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    rf_wb_sched_if #(.DATA_W(16), .ADDR_W(5)) bus ();
    rf_wb_sched #(.DATA_W(16), .ADDR_W(5), .NREGS(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: pending writes per register, who wins a tie, and the bank-side outputs
    bit        m_busy[16];
    bit        m_pref_mem = 1'b0;
    bit        m_we = 1'b0;
    bit [4:0]  m_rd = '0;
    bit [15:0] m_wd = '0;
    bit [15:0] m_cnt = '0;

    function automatic bit tracked(input bit [4:0] a);
        return a < 16 && !(ZR && a == 0);
    endfunction

    function automatic bit pending(input bit [4:0] a, input bit gv, input bit [4:0] grd);
        if (!tracked(a)) return 1'b0;
        if (gv && grd == a) return 1'b0;
        return m_busy[a];
    endfunction

    always @(negedge clk) begin : model
        bit aw, mw, gv, ir;
        bit [4:0] grd;
        bit [15:0] gwd;
        if (bus.alu_valid && bus.mem_valid) begin
            aw = !m_pref_mem;
            mw = m_pref_mem;
        end else begin
            aw = bus.alu_valid;
            mw = bus.mem_valid;
        end
        gv  = aw || mw;
        grd = aw ? bus.alu_rd : bus.mem_rd;
        gwd = aw ? bus.alu_wd : bus.mem_wd;
        ir  = !pending(bus.iss_rd, gv, grd);
        check("alu_ready", bus.alu_ready, aw);
        check("mem_ready", bus.mem_ready, mw);
        check("iss_ready", bus.iss_ready, ir);
        check("qa_busy", bus.qa_busy, pending(bus.qa, gv, grd));
        check("qb_busy", bus.qb_busy, pending(bus.qb, gv, grd));
        check("rf_we", bus.rf_we, m_we);
        check("rf_rd", bus.rf_rd, m_rd);
        check("rf_wd", bus.rf_wd, m_wd);
        check("commit_cnt", bus.commit_cnt, m_cnt);
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_pref_mem = 1'b0;
            m_we = 1'b0;
            m_rd = '0;
            m_wd = '0;
            m_cnt = '0;
        end else begin
            m_we = gv && tracked(grd);
            if (gv) begin
                m_pref_mem = aw;
                m_rd = grd;
                m_wd = gwd;
            end
            if (m_we) begin
                m_busy[grd] = 1'b0;
                m_cnt = m_cnt + 16'd1;
            end
            if (bus.iss_valid && ir && tracked(bus.iss_rd)) m_busy[bus.iss_rd] = 1'b1;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic iv, input logic [4:0] ir, input logic av, input logic [4:0] ar,
                          input logic [15:0] aw, input logic mv, input logic [4:0] mr, input logic [15:0] mw);
        bus.iss_valid = iv;
        bus.iss_rd    = ir;
        bus.alu_valid = av;
        bus.alu_rd    = ar;
        bus.alu_wd    = aw;
        bus.mem_valid = mv;
        bus.mem_rd    = mr;
        bus.mem_wd    = mw;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        bus.qa = '0;
        bus.qb = '0;
        nxt();
        nxt();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            check("idle rf_we", bus.rf_we, 0);
            check("idle commit_cnt", bus.commit_cnt, 0);
            nxt();
        end
        for (int q = 0; q < 20; q++) begin
            bus.qa = 5'(q);
            bus.qb = 5'(19 - q);
            smp();
            check("idle qa_busy", bus.qa_busy, 0);
            check("idle qb_busy", bus.qb_busy, 0);
            nxt();
        end
        // reserve r3, write it back two cycles later
        set_in(1, 3, 0, 0, 0, 0, 0, 0);
        smp();
        check("r3 iss_ready", bus.iss_ready, 1);
        nxt();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        bus.qa = 5'd3;
        smp();
        check("r3 busy", bus.qa_busy, 1);
        nxt();
        smp();
        check("r3 still busy", bus.qa_busy, 1);
        nxt();
        set_in(0, 0, 1, 3, 16'h1234, 0, 0, 0);
        smp();
        check("r3 alu_ready", bus.alu_ready, 1);
        check("r3 masked", bus.qa_busy, 0);
        nxt();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        smp();
        check("r3 rf_we", bus.rf_we, 1);
        check("r3 rf_rd", bus.rf_rd, 3);
        check("r3 rf_wd", bus.rf_wd, 16'h1234);
        check("r3 cleared", bus.qa_busy, 0);
        check("r3 commit_cnt", bus.commit_cnt, 1);
        nxt();
        // round robin after reset
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_in(0, 0, 1, 4, 16'h4440 + 16'(k), 1, 5, 16'h5555);
            smp();
            check("rr alu_ready", bus.alu_ready, 32'(k % 2 == 0));
            check("rr mem_ready", bus.mem_ready, 32'(k % 2 == 1));
            if (k > 0) check("rr rf_rd", bus.rf_rd, (k % 2 == 1) ? 4 : 5);
            nxt();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        smp();
        check("rr last rf_rd", bus.rf_rd, 5);
        check("rr last rf_we", bus.rf_we, 1);
        nxt();
        // WAW stall on r7
        set_in(1, 7, 0, 0, 0, 0, 0, 0);
        smp();
        check("r7 reserve", bus.iss_ready, 1);
        nxt();
        for (int i = 0; i < 2; i++) begin
            smp();
            check("r7 stall", bus.iss_ready, 0);
            nxt();
        end
        set_in(1, 7, 1, 7, 16'h7777, 0, 0, 0);
        smp();
        check("r7 grant iss_ready", bus.iss_ready, 1);
        check("r7 alu_ready", bus.alu_ready, 1);
        nxt();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        bus.qa = 5'd7;
        smp();
        check("r7 set wins", bus.qa_busy, 1);
        nxt();
        set_in(0, 0, 0, 0, 0, 1, 7, 16'h0707);
        smp();
        check("r7 mem_ready", bus.mem_ready, 1);
        check("r7 masked", bus.qa_busy, 0);
        nxt();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        smp();
        check("r7 cleared", bus.qa_busy, 0);
        check("r7 rf_wd", bus.rf_wd, 16'h0707);
        nxt();
        // reset right after a grant
        set_in(1, 9, 0, 0, 0, 0, 0, 0);
        nxt();
        set_in(0, 0, 1, 2, 16'h2222, 1, 10, 16'hAAAA);
        smp();
        check("pre-rst alu_ready", bus.alu_ready, 1);
        check("pre-rst mem_ready", bus.mem_ready, 0);
        nxt();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        smp();
        check("pre-rst rf_we", bus.rf_we, 1);
        nxt();
        rst = 1'b0;
        bus.qa = 5'd9;
        smp();
        check("post-rst rf_we", bus.rf_we, 0);
        check("post-rst commit_cnt", bus.commit_cnt, 0);
        check("post-rst r9 busy", bus.qa_busy, 0);
        nxt();
        set_in(0, 0, 1, 2, 16'h2222, 1, 10, 16'hAAAA);
        smp();
        check("post-rst ptr alu", bus.alu_ready, 1);
        nxt();
        // write-back to register 0
        set_in(0, 0, 0, 0, 0, 1, 0, 16'hBEEF);
        smp();
        check("r0 mem_ready", bus.mem_ready, 1);
        nxt();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        smp();
        check("r0 rf_we", bus.rf_we, ZR ? 0 : 1);
        check("r0 rf_rd", bus.rf_rd, 0);
        check("r0 rf_wd", bus.rf_wd, 16'hBEEF);
        check("r0 commit_cnt", bus.commit_cnt, ZR ? 1 : 2);
        nxt();
        // randomized traffic, checked by the model process
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            set_in($urandom_range(0, 1) == 1, 5'($urandom_range(0, 19)),
                   $urandom_range(0, 2) != 0, 5'($urandom_range(0, 19)), 16'($urandom),
                   $urandom_range(0, 2) != 0, 5'($urandom_range(0, 19)), 16'($urandom));
            bus.qa = 5'($urandom_range(0, 19));
            bus.qb = 5'($urandom_range(0, 19));
            nxt();
        end
        smp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
